rs_alu: RTL and testbench

- Reservation station for the integer ALU in the Tomasulo out-of-order core.
- Receives decoded ALU, branch, jump and U-type instructions from the issue stage and holds them until both operands are valid.
- Snoops the ALU and LSB broadcast buses (CDB) to fill missing operands.
- Dispatches at most one ready instruction per cycle to the ALU as a registered operand bundle.

---
 rtl/rs_alu_pkg.sv | 33 +++
 rtl/rs_alu_if.sv | 51 +++++
 rtl/rs_alu_select.sv | 18 +
 rtl/rs_alu.sv | 165 ++++++++++++++++
 tb/tb_rs_alu.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_alu_pkg.sv
// Shared constants and op encodings for the ALU reservation station.
// Optional feature macro: RS_ALU_PERF_CNT_EN (see rs_alu.sv).
package rs_alu_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int TAG_W_DEF   = 4;
    localparam int OP_W        = 6;
    localparam int DATA_W      = 32;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_ADDI  = 6'd9,
        OP_SLTI  = 6'd10,
        OP_XORI  = 6'd11,
        OP_SLLI  = 6'd12,
        OP_SRLI  = 6'd13,
        OP_ADD   = 6'd14,
        OP_SUB   = 6'd15,
        OP_AND   = 6'd16,
        OP_OR    = 6'd17,
        OP_XOR   = 6'd18,
        OP_SLT   = 6'd19
    } op_e;

endpackage

// File: rtl/rs_alu_if.sv
// Issue, CDB snoop and dispatch signals of the ALU reservation station.
// master = issue stage / CDB / ALU side, slave = the station itself.
interface rs_alu_if import rs_alu_pkg::*; #(
    parameter int TAG_W = TAG_W_DEF
) ();
    logic              issue_valid;
    logic [OP_W-1:0]   issue_op;
    logic [31:0]       issue_instruction;
    logic [31:0]       issue_pc;
    logic [31:0]       issue_imm;
    logic [31:0]       issue_vj;
    logic [31:0]       issue_vk;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic              issue_qj_busy;
    logic              issue_qk_busy;
    logic [TAG_W-1:0]  issue_entry;

    logic              alu_broadcast;
    logic [31:0]       alu_result;
    logic [TAG_W-1:0]  alu_entry;
    logic              lsb_broadcast;
    logic [31:0]       lsb_result;
    logic [TAG_W-1:0]  lsb_entry;

    logic              rs_full;
    logic              new_calculate;
    logic [OP_W-1:0]   op;
    logic [31:0]       instruction;
    logic [31:0]       vj;
    logic [31:0]       vk;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [TAG_W-1:0]  entry;

    modport master (
        output issue_valid, issue_op, issue_instruction, issue_pc, issue_imm,
               issue_vj, issue_vk, issue_qj, issue_qk, issue_qj_busy, issue_qk_busy,
               issue_entry, alu_broadcast, alu_result, alu_entry,
               lsb_broadcast, lsb_result, lsb_entry,
        input  rs_full, new_calculate, op, instruction, vj, vk, pc, imm, entry
    );

    modport slave (
        input  issue_valid, issue_op, issue_instruction, issue_pc, issue_imm,
               issue_vj, issue_vk, issue_qj, issue_qk, issue_qj_busy, issue_qk_busy,
               issue_entry, alu_broadcast, alu_result, alu_entry,
               lsb_broadcast, lsb_result, lsb_entry,
        output rs_full, new_calculate, op, instruction, vj, vk, pc, imm, entry
    );
endinterface

// File: rtl/rs_alu_select.sv
// rs_select: lowest-index priority encoder returning {found, index}.
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        // Scanning downward leaves the lowest set bit as the final winner.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end
endmodule

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: holds issued ops, snoops both CDBs,
// dispatches the lowest-index ready entry. Macro RS_ALU_PERF_CNT_EN adds perf counters.
module rs_alu import rs_alu_pkg::*; #(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rollback_in,
    rs_alu_if.slave     bus
`ifdef RS_ALU_PERF_CNT_EN
    ,
    output logic [31:0] perf_dispatch_cnt,
    output logic [31:0] perf_full_cycles
`endif
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d, qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
    logic [TAG_W-1:0]   qj_q [RS_SIZE], qj_d [RS_SIZE], qk_q [RS_SIZE], qk_d [RS_SIZE];
    logic [TAG_W-1:0]   ent_q [RS_SIZE], ent_d [RS_SIZE];
    logic [OP_W-1:0]    op_q [RS_SIZE], op_d [RS_SIZE];
    logic [31:0]        vj_q [RS_SIZE], vj_d [RS_SIZE], vk_q [RS_SIZE], vk_d [RS_SIZE];
    logic [31:0]        ins_q [RS_SIZE], ins_d [RS_SIZE], pc_q [RS_SIZE], pc_d [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE], imm_d [RS_SIZE];

    logic               nc_q, nc_d;
    logic [OP_W-1:0]    out_op_q, out_op_d;
    logic [31:0]        out_ins_q, out_ins_d, out_vj_q, out_vj_d, out_vk_q, out_vk_d;
    logic [31:0]        out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [TAG_W-1:0]   out_ent_q, out_ent_d;

    logic               free_found, rdy_found;
    logic [IDX_W-1:0]   free_idx, rdy_idx;
    logic [RS_SIZE-1:0] ready_vec;
    logic               iss_jb, iss_kb;
    logic [31:0]        iss_vj, iss_vk;

    assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .req_i(~busy_q), .found_o(free_found), .idx_o(free_idx)
    );
    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
        .req_i(ready_vec), .found_o(rdy_found), .idx_o(rdy_idx)
    );

    always_comb begin
        busy_d = busy_q;   qj_busy_d = qj_busy_q; qk_busy_d = qk_busy_q;
        qj_d   = qj_q;     qk_d      = qk_q;      ent_d     = ent_q;   op_d = op_q;
        vj_d   = vj_q;     vk_d      = vk_q;      ins_d     = ins_q;   pc_d = pc_q;
        imm_d  = imm_q;
        nc_d      = 1'b0;
        out_op_d  = out_op_q;  out_ins_d = out_ins_q; out_vj_d  = out_vj_q;
        out_vk_d  = out_vk_q;  out_pc_d  = out_pc_q;  out_imm_d = out_imm_q;
        out_ent_d = out_ent_q;

        // Same-cycle bypass so an operand produced while issuing is not missed.
        iss_vj = bus.issue_vj;  iss_jb = bus.issue_qj_busy;
        iss_vk = bus.issue_vk;  iss_kb = bus.issue_qk_busy;
        if (iss_jb && bus.alu_broadcast && bus.issue_qj == bus.alu_entry) begin
            iss_vj = bus.alu_result; iss_jb = 1'b0;
        end else if (iss_jb && bus.lsb_broadcast && bus.issue_qj == bus.lsb_entry) begin
            iss_vj = bus.lsb_result; iss_jb = 1'b0;
        end
        if (iss_kb && bus.alu_broadcast && bus.issue_qk == bus.alu_entry) begin
            iss_vk = bus.alu_result; iss_kb = 1'b0;
        end else if (iss_kb && bus.lsb_broadcast && bus.issue_qk == bus.lsb_entry) begin
            iss_vk = bus.lsb_result; iss_kb = 1'b0;
        end

        if (rollback_in) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (bus.alu_broadcast && qj_q[i] == bus.alu_entry) begin
                        vj_d[i] = bus.alu_result; qj_busy_d[i] = 1'b0;
                    end else if (bus.lsb_broadcast && qj_q[i] == bus.lsb_entry) begin
                        vj_d[i] = bus.lsb_result; qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (bus.alu_broadcast && qk_q[i] == bus.alu_entry) begin
                        vk_d[i] = bus.alu_result; qk_busy_d[i] = 1'b0;
                    end else if (bus.lsb_broadcast && qk_q[i] == bus.lsb_entry) begin
                        vk_d[i] = bus.lsb_result; qk_busy_d[i] = 1'b0;
                    end
                end
            end

            if (rdy_found) begin
                nc_d      = 1'b1;
                out_op_d  = op_q[rdy_idx];  out_ins_d = ins_q[rdy_idx];
                out_vj_d  = vj_q[rdy_idx];  out_vk_d  = vk_q[rdy_idx];
                out_pc_d  = pc_q[rdy_idx];  out_imm_d = imm_q[rdy_idx];
                out_ent_d = ent_q[rdy_idx];
                busy_d[rdy_idx] = 1'b0;
            end

            // Free slot comes from pre-dispatch state, so it never collides with rdy_idx.
            if (bus.issue_valid && free_found) begin
                busy_d[free_idx]    = 1'b1;
                qj_busy_d[free_idx] = iss_jb;           qk_busy_d[free_idx] = iss_kb;
                qj_d[free_idx]      = bus.issue_qj;     qk_d[free_idx]      = bus.issue_qk;
                vj_d[free_idx]      = iss_vj;           vk_d[free_idx]      = iss_vk;
                op_d[free_idx]      = bus.issue_op;     ins_d[free_idx]     = bus.issue_instruction;
                pc_d[free_idx]      = bus.issue_pc;     imm_d[free_idx]     = bus.issue_imm;
                ent_d[free_idx]     = bus.issue_entry;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q    <= '0;  qj_busy_q <= '0;  qk_busy_q <= '0;
            nc_q      <= 1'b0;
            out_op_q  <= '0;  out_ins_q <= '0;  out_vj_q  <= '0;  out_vk_q <= '0;
            out_pc_q  <= '0;  out_imm_q <= '0;  out_ent_q <= '0;
        end else if (rdy_in) begin
            busy_q    <= busy_d;    qj_busy_q <= qj_busy_d; qk_busy_q <= qk_busy_d;
            nc_q      <= nc_d;
            out_op_q  <= out_op_d;  out_ins_q <= out_ins_d; out_vj_q  <= out_vj_d;
            out_vk_q  <= out_vk_d;  out_pc_q  <= out_pc_d;  out_imm_q <= out_imm_d;
            out_ent_q <= out_ent_d;
        end
    end

    // Payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            qj_q  <= qj_d;   qk_q  <= qk_d;   ent_q <= ent_d;  op_q <= op_d;
            vj_q  <= vj_d;   vk_q  <= vk_d;   ins_q <= ins_d;  pc_q <= pc_d;
            imm_q <= imm_d;
        end
    end

    assign bus.rs_full       = ~free_found;
    assign bus.new_calculate = nc_q;
    assign bus.op            = out_op_q;
    assign bus.instruction   = out_ins_q;
    assign bus.vj            = out_vj_q;
    assign bus.vk            = out_vk_q;
    assign bus.pc            = out_pc_q;
    assign bus.imm           = out_imm_q;
    assign bus.entry         = out_ent_q;

`ifdef RS_ALU_PERF_CNT_EN
    logic [31:0] perf_disp_q, perf_full_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_disp_q <= '0;
            perf_full_q <= '0;
        end else if (rdy_in) begin
            if (nc_d)        perf_disp_q <= perf_disp_q + 32'd1;
            if (bus.rs_full) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_dispatch_cnt = perf_disp_q;
    assign perf_full_cycles  = perf_full_q;
`endif
endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus random traffic,
// every cycle compared against a slot-table reference model.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy, rollback;
    int   tests = 0;
    int   fails = 0;

    rs_alu_if #(.TAG_W(4)) bus ();

    rs_alu #(.RS_SIZE(16), .TAG_W(4)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rollback_in(rollback), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy, jb, kb;
        logic [3:0]  qj, qk, ent;
        logic [31:0] vj, vk, pc, imm, ins;
        logic [5:0]  op;
    } ment_t;

    ment_t       m [16];
    logic        exp_nc;
    logic [5:0]  e_op;
    logic [31:0] e_ins, e_vj, e_vk, e_pc, e_imm;
    logic [3:0]  e_ent;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < 16; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    // Returns {still_pending, value} after looking at both buses (ALU wins).
    function automatic logic [32:0] resolve(input bit pend, input logic [31:0] v, input logic [3:0] tag);
        if (pend && bus.alu_broadcast && bus.alu_entry == tag) return {1'b0, bus.alu_result};
        if (pend && bus.lsb_broadcast && bus.lsb_entry == tag) return {1'b0, bus.lsb_result};
        return {pend, v};
    endfunction

    task automatic model_edge();
        int d = -1;
        int f = -1;
        if (!rdy) return;
        if (rollback) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            exp_nc = 1'b0;
            return;
        end
        for (int i = 15; i >= 0; i--) begin
            if (m[i].busy && !m[i].jb && !m[i].kb) d = i;
            if (!m[i].busy) f = i;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy) begin
                {m[i].jb, m[i].vj} = resolve(m[i].jb, m[i].vj, m[i].qj);
                {m[i].kb, m[i].vk} = resolve(m[i].kb, m[i].vk, m[i].qk);
            end
        end
        if (d >= 0) begin
            exp_nc = 1'b1;
            e_op = m[d].op; e_ins = m[d].ins; e_vj = m[d].vj; e_vk = m[d].vk;
            e_pc = m[d].pc; e_imm = m[d].imm; e_ent = m[d].ent;
            m[d].busy = 1'b0;
        end else begin
            exp_nc = 1'b0;
        end
        if (bus.issue_valid && f >= 0) begin
            m[f].busy = 1'b1;
            m[f].qj = bus.issue_qj;  m[f].qk = bus.issue_qk;  m[f].ent = bus.issue_entry;
            m[f].op = bus.issue_op;  m[f].ins = bus.issue_instruction;
            m[f].pc = bus.issue_pc;  m[f].imm = bus.issue_imm;
            {m[f].jb, m[f].vj} = resolve(bus.issue_qj_busy, bus.issue_vj, bus.issue_qj);
            {m[f].kb, m[f].vk} = resolve(bus.issue_qk_busy, bus.issue_vk, bus.issue_qk);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("new_calculate", bus.new_calculate, exp_nc);
        chk("bundle", {bus.op, bus.instruction, bus.vj, bus.vk, bus.pc, bus.imm, bus.entry},
                      {e_op, e_ins, e_vj, e_vk, e_pc, e_imm, e_ent});
        chk("rs_full", bus.rs_full, m_full());
    endtask

    task automatic idle();
        rdy = 1'b1; rollback = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_instruction = '0;
        bus.issue_pc = '0; bus.issue_imm = '0; bus.issue_vj = '0; bus.issue_vk = '0;
        bus.issue_qj = '0; bus.issue_qk = '0; bus.issue_qj_busy = 1'b0;
        bus.issue_qk_busy = 1'b0; bus.issue_entry = '0;
        bus.alu_broadcast = 1'b0; bus.alu_result = '0; bus.alu_entry = '0;
        bus.lsb_broadcast = 1'b0; bus.lsb_result = '0; bus.lsb_entry = '0;
    endtask

    task automatic set_issue(input op_e op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [3:0] qj, input bit jb, input logic [3:0] qk, input bit kb,
                             input logic [3:0] ent, input logic [31:0] imm);
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.issue_vj = vj; bus.issue_vk = vk;
        bus.issue_qj = qj; bus.issue_qj_busy = jb; bus.issue_qk = qk; bus.issue_qk_busy = kb;
        bus.issue_entry = ent; bus.issue_imm = imm;
        bus.issue_pc = $urandom; bus.issue_instruction = $urandom;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m[i] = '{default: '0};
        exp_nc = 1'b0; e_op = '0; e_ins = '0; e_vj = '0; e_vk = '0; e_pc = '0; e_imm = '0; e_ent = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_nc", bus.new_calculate, 1'b0);
        chk("reset_full", bus.rs_full, 1'b0);
        chk("reset_bundle", {bus.op, bus.instruction, bus.vj, bus.vk, bus.pc, bus.imm, bus.entry}, 170'd0);
        rst = 1'b0;

        // ADDI with both operands ready dispatches one edge after issue.
        set_issue(OP_ADDI, 32'd5, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 32'd3);
        step(); idle();
        chk("addi_no_early", bus.new_calculate, 1'b0);
        step();
        chk("addi_nc", bus.new_calculate, 1'b1);
        chk("addi_fields", {bus.op, bus.vj, bus.imm, bus.entry}, {OP_ADDI, 32'd5, 32'd3, 4'd2});
        step();
        chk("addi_pulse_end", bus.new_calculate, 1'b0);

        // ADD waiting on tag 7, woken by the ALU bus.
        set_issue(OP_ADD, 32'd0, 32'd1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd3, 32'd0);
        step(); idle();
        bus.alu_broadcast = 1'b1; bus.alu_entry = 4'd7; bus.alu_result = 32'h10;
        step(); idle();
        chk("wake_not_same_cycle", bus.new_calculate, 1'b0);
        step();
        chk("wake_vj", {bus.new_calculate, bus.vj}, {1'b1, 32'h10});

        // Issue-time bypass from the LSB bus.
        set_issue(OP_SUB, 32'd9, 32'd0, 4'd0, 1'b0, 4'd3, 1'b1, 4'd5, 32'd0);
        bus.lsb_broadcast = 1'b1; bus.lsb_entry = 4'd3; bus.lsb_result = 32'hABCD;
        step(); idle();
        step();
        chk("bypass_vk", {bus.new_calculate, bus.vk}, {1'b1, 32'hABCD});
        step();

        // Fill all 16 slots, each waiting on its own tag.
        for (int i = 0; i < 16; i++) begin
            set_issue(OP_ADD, 32'd0, 32'd0, 4'(i), 1'b1, 4'd0, 1'b0, 4'(i), 32'd0);
            step();
        end
        chk("full_after_16", bus.rs_full, 1'b1);
        set_issue(OP_ADDI, 32'hDEAD, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'hE, 32'd1);
        step(); idle();
        chk("17th_dropped", {bus.rs_full, bus.new_calculate}, 2'b10);
        bus.alu_broadcast = 1'b1; bus.alu_entry = 4'd0; bus.alu_result = 32'h55;
        step(); idle();
        chk("full_before_dispatch", bus.rs_full, 1'b1);
        step();
        chk("full_drain", {bus.new_calculate, bus.entry, bus.vj, bus.rs_full}, {1'b1, 4'd0, 32'h55, 1'b0});
        rollback = 1'b1;
        step(); idle();

        // Slots 1 and 4 wake together; lowest index wins.
        for (int i = 0; i < 5; i++) begin
            set_issue(OP_XOR, 32'd0, 32'(i), (i == 1 || i == 4) ? 4'd6 : 4'd5, 1'b1,
                      4'd0, 1'b0, 4'(8 + i), 32'd0);
            step();
        end
        idle();
        bus.alu_broadcast = 1'b1; bus.alu_entry = 4'd6; bus.alu_result = 32'h66;
        step(); idle();
        step();
        chk("prio_first", {bus.new_calculate, bus.entry}, {1'b1, 4'd9});
        step();
        chk("prio_second", {bus.new_calculate, bus.entry}, {1'b1, 4'd12});
        step();

        // Five busy, then rollback together with an issue.
        for (int i = 0; i < 2; i++) begin
            set_issue(OP_OR, 32'd0, 32'd0, 4'd5, 1'b1, 4'd0, 1'b0, 4'(1 + i), 32'd0);
            step();
        end
        set_issue(OP_ADDI, 32'd7, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 32'd1);
        rollback = 1'b1;
        step(); idle();
        chk("rollback", {bus.rs_full, bus.new_calculate}, 2'b00);
        step();
        chk("rollback_no_dispatch", bus.new_calculate, 1'b0);

        // rdy_in low freezes a live dispatch pulse and blocks the pending one.
        set_issue(OP_AND, 32'h1234, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 32'd0);
        step();
        set_issue(OP_OR, 32'h4321, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 32'd0);
        step();
        for (int c = 0; c < 3; c++) begin
            set_issue(OP_SLT, 32'd1, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 32'd0);
            rdy = 1'b0;
            step();
            chk("frozen", {bus.new_calculate, bus.vj, bus.entry}, {1'b1, 32'h1234, 4'd3});
        end
        idle();
        step();
        chk("thaw", {bus.new_calculate, bus.vj, bus.entry}, {1'b1, 32'h4321, 4'd4});
        step();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            idle();
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 6)
                set_issue(op_e'(6'($urandom_range(1, 19))), $urandom, $urandom,
                          4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                          4'($urandom), $urandom);
            bus.alu_broadcast = ($urandom_range(0, 9) < 4);
            bus.alu_entry     = 4'($urandom);
            bus.alu_result    = $urandom;
            bus.lsb_broadcast = ($urandom_range(0, 9) < 3);
            bus.lsb_entry     = 4'($urandom);
            bus.lsb_result    = $urandom;
            if (bus.alu_broadcast && bus.lsb_broadcast && bus.lsb_entry == bus.alu_entry)
                bus.lsb_entry = bus.alu_entry + 4'd1;
            step();
        end
        idle();
        rollback = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
